// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: walks a low row, synchronises and debounces the columns,
// and pulses a 4-bit key code for one cycle. Define KEY_REPEAT_EN to auto-repeat held keys.
module key_scan #(
    parameter int SCAN_DIV      = 50000,
    parameter int DEB_TICKS     = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_val_out,
    output logic       key_valid
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [3:0] KEY_MAP [0:15] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    if (SCAN_DIV < 4 || DEB_TICKS < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_scan: parameter out of range");
    end

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    col_meta, col;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    row_nxt, row_rot;
    logic [3:0]    latched, latched_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [DW-1:0] rel_cnt, rel_nxt;
    logic          emit;
    logic [3:0]    key_code;

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          rep_phase, rep_nxt;
`endif

    // Lowest-index closed column wins when several are low on the held row.
    function automatic logic [3:0] encode(input logic [3:0] row, input logic [3:0] cols);
        logic [1:0] r;
        logic [1:0] c;
        r = 2'd0;
        c = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row[i])  r = 2'(i);
            if (!cols[i]) c = 2'(i);
        end
        return KEY_MAP[{r, c}];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col      <= 4'hF;
        end else begin
            col_meta <= col_in;
            col      <= col_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick     = (tick_cnt == TICK_LAST);
    assign row_rot  = {row_out[2:0], row_out[3]};
    assign key_code = encode(row_out, latched);

    // Counters stop at their last value because every terminal count changes state.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row_out;
        latched_nxt = latched;
        deb_nxt     = deb_cnt;
        rel_nxt     = rel_cnt;
        emit        = 1'b0;
`ifdef KEY_REPEAT_EN
        hold_nxt    = hold_cnt;
        rep_nxt     = rep_phase;
`endif
        if (tick) begin
            case (state)
                SCAN: begin
                    if (col == 4'hF) begin
                        row_nxt = row_rot;
                    end else begin
                        latched_nxt = col;
                        deb_nxt     = DW'(1);
                        state_nxt   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (col == latched) begin
                        if (deb_cnt == DEB_LAST) begin
                            emit      = 1'b1;
                            deb_nxt   = '0;
                            rel_nxt   = '0;
                            state_nxt = HOLD;
                        end else begin
                            deb_nxt = deb_cnt + 1'b1;
                        end
                    end else begin
                        row_nxt   = row_rot;
                        deb_nxt   = '0;
                        state_nxt = SCAN;
                    end
                end
                HOLD: begin
                    if (col == 4'hF) begin
                        if (rel_cnt == DEB_LAST) begin
                            row_nxt   = row_rot;
                            rel_nxt   = '0;
                            deb_nxt   = '0;
                            state_nxt = SCAN;
                        end else begin
                            rel_nxt = rel_cnt + 1'b1;
                        end
                    end else begin
                        rel_nxt = '0;
                    end
`ifdef KEY_REPEAT_EN
                    // First repeat after REPEAT_DELAY steady ticks, then every REPEAT_PERIOD.
                    if (col == latched) begin
                        if (!rep_phase && hold_cnt == DELAY_LAST) begin
                            emit     = 1'b1;
                            hold_nxt = '0;
                            rep_nxt  = 1'b1;
                        end else if (rep_phase && hold_cnt == PERIOD_LAST) begin
                            emit     = 1'b1;
                            hold_nxt = '0;
                        end else begin
                            hold_nxt = hold_cnt + 1'b1;
                        end
                    end else begin
                        hold_nxt = '0;
                        rep_nxt  = 1'b0;
                    end
`endif
                end
                default: begin
                    state_nxt = SCAN;
                    row_nxt   = 4'b1110;
                    deb_nxt   = '0;
                    rel_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            row_out     <= 4'b1110;
            latched     <= 4'hF;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            key_valid   <= 1'b0;
            key_val_out <= 4'hF;
        end else begin
            state       <= state_nxt;
            row_out     <= row_nxt;
            latched     <= latched_nxt;
            deb_cnt     <= deb_nxt;
            rel_cnt     <= rel_nxt;
            key_valid   <= emit;
            key_val_out <= emit ? key_code : 4'hF;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
        end else begin
            hold_cnt  <= hold_nxt;
            rep_phase <= rep_nxt;
        end
    end
`endif

endmodule
